race_ctl: RTL and testbench
===========================

// Module: race_ctl
// PURPOSE
//  Per-frame motion and race sequencer for one player car. It produces the car_xpos/car_ypos
//  inputs of the car sprite drawing stage. Runs the IDLE/COUNTDOWN/RACE/FINISH race FSM.
//  Integrates throttle into speed and speed into position once per video frame.
//  Sits between the button synchroniser and the sprite drawing pipeline; timing comes from the vblnk of the VGA timing chain.
// PARAMETERS
//  START_X    20    car x position (px) at IDLE/COUNTDOWN
//  START_Y    600   car y position (px), constant
//  FINISH_X   680   x position (px) that ends the race
//  FPS        60    frame ticks per countdown step
//  ACCEL      2     speed increment per frame with throttle (1/16 px/frame units)
//  DRAG       1     speed decrement per frame without throttle (same units)
//  MAX_SPEED  128   speed ceiling (same units) = 8 px/frame
// PORTS
//  clk        in   1   pixel clock
//  reset      in   1   synchronous, active-high
//  vblnk      in   1   vertical blank from timing generator
//  start      in   1   start/restart button, level, already synchronised
//  throttle   in   1   accelerator button, level, already synchronised
//  car_xpos   out  12  sprite x position (px)
//  car_ypos   out  12  sprite y position (px)
//  race_state out  2   0=IDLE 1=COUNTDOWN 2=RACE 3=FINISH
//  countdown  out  2   3,2,1 during COUNTDOWN, else 0
//  jump_start out  1   throttle was seen during COUNTDOWN; sticky until next start
//  race_time  out  16  frames spent in RACE, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset values: car_xpos=START_X, car_ypos=START_Y, race_state=IDLE, countdown=0,
//   jump_start=0, race_time=0, speed=0, pos_acc={START_X,4'b0}.
//  tick = vblnk & ~vblnk_q, using a 1-cycle registered delay; tick fires exactly once per frame.
//  start_p = start & ~start_q. Both edge registers reset to 0.
//  pos_acc is 16 bit, 12.4 fixed point; car_xpos = pos_acc[15:4]. speed is 8 bit unsigned.
//  All outputs are registered. A state/position change caused by a tick or start_p is visible on the cycle after it.
//  IDLE: hold START position and speed=0. On start_p -> COUNTDOWN, with countdown=3, frame_cnt=0,
//   jump_start=0, race_time=0.
//  COUNTDOWN: on each tick, frame_cnt++. When frame_cnt reaches FPS-1 and a tick arrives,
//   frame_cnt=0 and countdown--. A tick with countdown==1 and frame_cnt==FPS-1 -> RACE, countdown=0.
//   The COUNTDOWN->RACE transition takes 3*FPS ticks (180 at default FPS).
//   If throttle=1 on any cycle here, jump_start=1. Position stays frozen.
//  RACE, on each tick:
//   speed_n = throttle ? min(speed+ACCEL, MAX_SPEED) : (speed<DRAG ? 0 : speed-DRAG).
//   pos_acc += speed_n. The new speed is used in the same tick. Compute with 9-bit/17-bit intermediates; no wrap.
//   race_time++ (saturating).
//   If the new pos_acc[15:4] >= FINISH_X: pos_acc={FINISH_X,4'b0}, speed=0, and -> FINISH.
//  FINISH: position, race_time and jump_start are frozen. On start_p -> IDLE, with position back at START.
//  Simultaneous tick and start_p in the same cycle:
//   COUNTDOWN and RACE ignore start_p; the tick is processed.
//   IDLE and FINISH act on start_p; the tick is ignored.
//  A tick while in IDLE/FINISH changes nothing.
//  Reset asserted mid-race returns every output to its reset value on the next clk edge. The car
//   is immediately redrawn at START.
//  car_ypos is constant START_Y. Outputs change only on clk edges and may change mid-frame by at
//   most one step. The sprite stage samples them every pixel.
// TESTING
//  1 Reset, then pulse start, with throttle=0 -> race_state=1 and countdown=3 one cycle after
//    start_p. After 60 ticks countdown=2, after 120 countdown=1, after 180 race_state=2.
//  2 In RACE, throttle held -> after tick n, speed=2n and car_xpos = 20 + n(n+1)/16.
//    Expect xpos=20 after 3 ticks, 21 after 4, 26 after 10. Speed reaches 128 at tick 64 and stays there.
//  3 Reach speed 10, then release throttle -> speed decrements 9,8,...,0 over 10 ticks, then stays 0.
//    car_xpos never decreases.
//  4 Full throttle to the finish -> car_xpos stops at exactly 680 and race_state=3.
//    race_time equals the number of RACE ticks. Further ticks change nothing. start -> IDLE, xpos=20.
//  5 Throttle pulsed during COUNTDOWN -> jump_start=1, held through RACE/FINISH.
//    Cleared at the next start_p from IDLE.
//  6 start and vblnk rise in the same cycle during RACE -> the tick is processed and the state stays RACE.
//    reset asserted mid-RACE -> car_xpos=20 and race_state=0 on the next cycle.

Source files
------------

// File: rtl/race_ctl.sv
// Per-frame race sequencer for one player car: IDLE/COUNTDOWN/RACE/FINISH FSM,
// throttle-to-speed-to-position integration once per vblnk rising edge.
module race_ctl #(
  parameter int START_X   = 20,
  parameter int START_Y   = 600,
  parameter int FINISH_X  = 680,
  parameter int FPS       = 60,
  parameter int ACCEL     = 2,
  parameter int DRAG      = 1,
  parameter int MAX_SPEED = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vblnk,
  input  logic        start,
  input  logic        throttle,
  output logic [11:0] car_xpos,
  output logic [11:0] car_ypos,
  output logic [1:0]  race_state,
  output logic [1:0]  countdown,
  output logic        jump_start,
  output logic [15:0] race_time
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    RACE      = 2'd2,
    FINISH    = 2'd3
  } state_t;

  localparam int          FCW        = (FPS > 1) ? $clog2(FPS) : 1;
  localparam logic [15:0] START_ACC  = 16'(START_X * 16);
  localparam logic [15:0] FINISH_ACC = 16'(FINISH_X * 16);

  state_t         state_q, state_d;
  logic           vblnk_q, start_q;
  logic [1:0]     countdown_q, countdown_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]     speed_q, speed_d;
  logic [15:0]    pos_acc_q, pos_acc_d;
  logic           jump_start_q, jump_start_d;
  logic [15:0]    race_time_q, race_time_d;

  logic           tick, start_p;
  logic [8:0]     speed_sum;
  logic [7:0]     speed_n;
  logic [16:0]    pos_sum;

  always_comb begin
    tick    = vblnk & ~vblnk_q;
    start_p = start & ~start_q;

    // Wide intermediates keep the saturating speed and the finish compare free of wrap.
    speed_sum = {1'b0, speed_q} + 9'(ACCEL);
    speed_n   = speed_q;
    if (throttle)
      speed_n = (speed_sum > 9'(MAX_SPEED)) ? 8'(MAX_SPEED) : speed_sum[7:0];
    else
      speed_n = (speed_q < 8'(DRAG)) ? 8'd0 : speed_q - 8'(DRAG);
    pos_sum = {1'b0, pos_acc_q} + 17'(speed_n);

    state_d      = state_q;
    countdown_d  = countdown_q;
    frame_cnt_d  = frame_cnt_q;
    speed_d      = speed_q;
    pos_acc_d    = pos_acc_q;
    jump_start_d = jump_start_q;
    race_time_d  = race_time_q;

    unique case (state_q)
      IDLE: begin
        speed_d   = 8'd0;
        pos_acc_d = START_ACC;
        if (start_p) begin
          state_d      = COUNTDOWN;
          countdown_d  = 2'd3;
          frame_cnt_d  = '0;
          jump_start_d = 1'b0;
          race_time_d  = 16'd0;
        end
      end
      COUNTDOWN: begin
        if (throttle) jump_start_d = 1'b1;
        if (tick) begin
          if (frame_cnt_q == FCW'(FPS - 1)) begin
            frame_cnt_d = '0;
            countdown_d = countdown_q - 2'd1;
            if (countdown_q == 2'd1) state_d = RACE;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      RACE: begin
        if (tick) begin
          speed_d     = speed_n;
          pos_acc_d   = pos_sum[15:0];
          race_time_d = (race_time_q == 16'hFFFF) ? race_time_q : race_time_q + 16'd1;
          if (pos_sum[16:4] >= 13'(FINISH_X)) begin
            pos_acc_d = FINISH_ACC;
            speed_d   = 8'd0;
            state_d   = FINISH;
          end
        end
      end
      FINISH: begin
        if (start_p) begin
          state_d   = IDLE;
          pos_acc_d = START_ACC;
          speed_d   = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      vblnk_q      <= 1'b0;
      start_q      <= 1'b0;
      countdown_q  <= 2'd0;
      frame_cnt_q  <= '0;
      speed_q      <= 8'd0;
      pos_acc_q    <= START_ACC;
      jump_start_q <= 1'b0;
      race_time_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      vblnk_q      <= vblnk;
      start_q      <= start;
      countdown_q  <= countdown_d;
      frame_cnt_q  <= frame_cnt_d;
      speed_q      <= speed_d;
      pos_acc_q    <= pos_acc_d;
      jump_start_q <= jump_start_d;
      race_time_q  <= race_time_d;
    end
  end

  assign car_xpos   = pos_acc_q[15:4];
  assign car_ypos   = 12'(START_Y);
  assign race_state = state_q;
  assign countdown  = countdown_q;
  assign jump_start = jump_start_q;
  assign race_time  = race_time_q;

endmodule

// File: tb/tb_race_ctl.sv
// Randomised bench for race_ctl against a tick-counting arithmetic model of the race rules.
module tb_race_ctl;
  localparam int FPS = 60;

  logic        clk = 1'b0;
  logic        reset, vblnk, start, throttle;
  logic [11:0] car_xpos, car_ypos;
  logic [1:0]  race_state, countdown;
  logic        jump_start;
  logic [15:0] race_time;

  int total = 0;
  int bad   = 0;

  // Model: countdown is derived from ticks elapsed; position kept in 1/16 px.
  int m_state, m_cdt, m_speed, m_pos, m_js, m_time;

  race_ctl dut (
    .clk(clk), .reset(reset), .vblnk(vblnk), .start(start), .throttle(throttle),
    .car_xpos(car_xpos), .car_ypos(car_ypos), .race_state(race_state),
    .countdown(countdown), .jump_start(jump_start), .race_time(race_time)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cdt = 0; m_speed = 0; m_pos = 20 * 16; m_js = 0; m_time = 0;
  endtask

  task automatic model_cycle(input bit sp, input bit tk, input bit thr);
    case (m_state)
      0: if (sp) begin m_state = 1; m_cdt = 0; m_js = 0; m_time = 0; end
      1: begin
        if (thr) m_js = 1;
        if (tk) begin
          m_cdt++;
          if (m_cdt == 3 * FPS) m_state = 2;
        end
      end
      2: if (tk) begin
        m_speed = thr ? ((m_speed + 2 > 128) ? 128 : m_speed + 2)
                      : ((m_speed < 1) ? 0 : m_speed - 1);
        m_pos += m_speed;
        if (m_time < 65535) m_time++;
        if (m_pos / 16 >= 680) begin m_pos = 680 * 16; m_speed = 0; m_state = 3; end
      end
      default: if (sp) begin m_state = 0; m_pos = 20 * 16; m_speed = 0; end
    endcase
  endtask

  function automatic int m_countdown();
    return (m_state == 1) ? 3 - m_cdt / FPS : 0;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ":xpos"},  car_xpos,   m_pos / 16);
    chk({tag, ":state"}, race_state, m_state);
    chk({tag, ":cd"},    countdown,  m_countdown());
    chk({tag, ":js"},    jump_start, m_js);
    chk({tag, ":time"},  race_time,  m_time);
  endtask

  // One event = two clocks: inputs applied for one cycle, then start/vblnk dropped.
  task automatic ev(input bit st, input bit vb, input bit thr);
    start = st; vblnk = vb; throttle = thr;
    @(posedge clk); model_cycle(st, vb, thr); #1;
    start = 1'b0; vblnk = 1'b0;
    @(posedge clk); model_cycle(1'b0, 1'b0, thr); #1;
  endtask

  task automatic run_countdown(input bit explicit_checks);
    for (int i = 1; i <= 3 * FPS; i++) begin
      ev(1'b0, 1'b1, 1'b0);
      check_all("cd_tick");
      if (explicit_checks && i == FPS)     chk("cd_after60", countdown, 2);
      if (explicit_checks && i == 2 * FPS) chk("cd_after120", countdown, 1);
    end
    if (explicit_checks) chk("race_after180", race_state, 2);
  endtask

  initial begin
    int prev_x;
    int n;
    reset = 1'b1; vblnk = 1'b0; start = 1'b0; throttle = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset:ypos", car_ypos, 600);
    check_all("reset");
    reset = 1'b0;

    ev(1'b0, 1'b1, 1'b1);
    check_all("idle_tick");

    // Race A: full throttle to the finish, checked against closed forms.
    ev(1'b1, 1'b0, 1'b0);
    chk("startA:state", race_state, 1);
    chk("startA:cd", countdown, 3);
    run_countdown(1'b1);
    n = 0;
    while (m_state == 2 && n < 400) begin
      n++;
      ev(1'b0, 1'b1, 1'b1);
      check_all("full_thr");
      if (n <= 64) chk("closed_form_accel", car_xpos, 20 + n * (n + 1) / 16);
      else if (n < 114) chk("closed_form_cruise", car_xpos, (4480 + 128 * (n - 64)) / 16);
      if (n == 3)  chk("x_at3", car_xpos, 20);
      if (n == 4)  chk("x_at4", car_xpos, 21);
      if (n == 10) chk("x_at10", car_xpos, 26);
    end
    chk("finishA:state", race_state, 3);
    chk("finishA:xpos", car_xpos, 680);
    chk("finishA:time", race_time, 114);
    for (int i = 0; i < 5; i++) begin
      ev(1'b0, 1'b1, 1'b1);
      check_all("finish_frozen");
    end
    ev(1'b1, 1'b1, 1'b0);
    chk("finishA_restart:state", race_state, 0);
    chk("finishA_restart:xpos", car_xpos, 20);
    check_all("finishA_restart");

    // Race B: jump start, coasting decay, start+tick in RACE, random throttle.
    ev(1'b1, 1'b1, 1'b0);
    check_all("startB_with_tick");
    ev(1'b0, 1'b0, 1'b1);
    chk("jump_seen", jump_start, 1);
    run_countdown(1'b0);
    for (int i = 0; i < 5; i++) ev(1'b0, 1'b1, 1'b1);
    check_all("speed10");
    chk("speed10:xpos", car_xpos, 21);
    prev_x = car_xpos;
    for (int i = 0; i < 15; i++) begin
      ev(1'b0, 1'b1, 1'b0);
      check_all("coast");
      chk("coast_monotonic", (car_xpos >= prev_x) ? 1 : 0, 1);
      prev_x = car_xpos;
    end
    chk("coast_end:xpos", car_xpos, 24);
    ev(1'b1, 1'b1, 1'b1);
    chk("start_tick_in_race:state", race_state, 2);
    check_all("start_tick_in_race");
    n = 0;
    while (m_state == 2 && n < 800) begin
      n++;
      ev(1'b0, 1'b1, ($urandom_range(0, 3) != 0));
      check_all("rand_race");
    end
    chk("finishB:state", race_state, 3);
    chk("finishB:js", jump_start, 1);
    ev(1'b1, 1'b0, 1'b0);
    chk("idleB:js_held", jump_start, 1);
    ev(1'b1, 1'b0, 1'b0);
    chk("startC:js_cleared", jump_start, 0);
    check_all("startC");

    // Race C: reset in the middle of a race.
    run_countdown(1'b0);
    for (int i = 0; i < 20; i++) ev(1'b0, 1'b1, ($urandom_range(0, 1) == 1));
    check_all("pre_reset");
    reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    chk("mid_reset:xpos", car_xpos, 20);
    chk("mid_reset:state", race_state, 0);
    check_all("mid_reset");
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
